nes_cmd_ctrl: RTL and testbench

Command sequencer between the host-visible AXI-lite register block and the NES core. The host writes a command word into register 0 (`value`). This block detects each new command by a toggle bit and executes it against the NES memory bus and the reset/pause controls. It then reports completion, status and read data through the word exposed at register 1 (`result`).

---
 rtl/nes_cmd_pkg.sv | 42 ++++
 rtl/nes_cmd_timer.sv | 25 ++
 rtl/nes_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_nes_cmd_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nes_cmd_pkg.sv
// Shared definitions for the NES command sequencer: opcodes, FSM states,
// command/result field positions and the reset-hold length helper.
package nes_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RST_HOLD,
    ST_MEM,
    ST_DONE
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RESET = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_PAUSE = 3'd4;

  localparam int CMD_TGL     = 31;
  localparam int CMD_OP_HI   = 30;
  localparam int CMD_OP_LO   = 28;
  localparam int CMD_ARG_HI  = 27;
  localparam int CMD_ADDR_HI = 23;
  localparam int CMD_ADDR_LO = 8;
  localparam int CMD_DATA_HI = 7;

  localparam int RES_ACK   = 31;
  localparam int RES_BUSY  = 30;
  localparam int RES_ERR   = 29;
  localparam int RES_OP_HI = 28;
  localparam int RES_OP_LO = 26;

  localparam int TMR_W = 16;

  // Timer expires when it reaches zero, so it is loaded with length-1.
  function automatic logic [TMR_W-1:0] hold_count(input logic [15:0] len, input int unsigned min_len);
    logic [TMR_W-1:0] m;
    m = TMR_W'(min_len);
    hold_count = (len < m) ? m - TMR_W'(1) : len - TMR_W'(1);
  endfunction

endpackage

// File: rtl/nes_cmd_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Load takes effect on the next edge; no backpressure.
module nes_cmd_timer import nes_cmd_pkg::*; (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/nes_cmd_ctrl.sv
// Host command sequencer for the NES core: NOP/RESET/WRITE/READ/PAUSE, ack via result toggle.
// NOP ack 3 edges after the toggle is sampled; host must await the ack. Watchdog: NES_CMD_TIMEOUT_EN.
module nes_cmd_ctrl import nes_cmd_pkg::*; #(
  parameter int RESET_MIN      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] value,
  output logic [31:0] result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        nes_reset,
  output logic        nes_pause
);

  state_t      state_q, state_d;
  logic [31:0] value_q;
  logic        tgl_q, tgl_d;
  logic [2:0]  op_q, op_d;
  logic [23:0] arg_q, arg_d;
  logic        ack_q, ack_d, busy_q, busy_d, err_q, err_d;
  logic [2:0]  last_op_q, last_op_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        mem_req_d, mem_we_d, nes_reset_d, nes_pause_d;
  logic [15:0] mem_addr_d;
  logic [7:0]  mem_wdata_d;
  logic             tmr_load, tmr_exp;
  logic [TMR_W-1:0] tmr_val;
  logic             unused_arg_bits;

  assign unused_arg_bits = ^value_q[CMD_ARG_HI:CMD_ADDR_HI+1];

  nes_cmd_timer u_timer (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .load          (tmr_load),
    .load_val      (tmr_val),
    .expired       (tmr_exp)
  );

  always_comb begin
    state_d     = state_q;
    tgl_d       = tgl_q;
    op_d        = op_q;
    arg_d       = arg_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    err_d       = err_q;
    last_op_d   = last_op_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    nes_reset_d = nes_reset;
    nes_pause_d = nes_pause;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      ST_IDLE: begin
        if (value_q[CMD_TGL] != ack_q) begin
          tgl_d   = value_q[CMD_TGL];
          op_d    = value_q[CMD_OP_HI:CMD_OP_LO];
          arg_d   = value_q[CMD_ADDR_HI:0];
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        case (op_q)
          OP_NOP: ;
          OP_RESET: begin
            nes_reset_d = 1'b1;
            tmr_load    = 1'b1;
            tmr_val     = hold_count(arg_q[15:0], RESET_MIN);
            state_d     = ST_RST_HOLD;
          end
          OP_WRITE, OP_READ: begin
            mem_req_d   = 1'b1;
            mem_we_d    = (op_q == OP_WRITE);
            mem_addr_d  = arg_q[CMD_ADDR_HI:CMD_ADDR_LO];
            mem_wdata_d = arg_q[CMD_DATA_HI:0];
            tmr_load    = 1'b1;
            tmr_val     = TMR_W'(TIMEOUT_CYCLES - 1);
            state_d     = ST_MEM;
          end
          OP_PAUSE: nes_pause_d = arg_q[0];
          default:  err_d = 1'b1;
        endcase
      end
      ST_RST_HOLD: begin
        if (tmr_exp) begin
          nes_reset_d = 1'b0;
          state_d     = ST_DONE;
        end
      end
      ST_MEM: begin
        // An ack landing on the same edge as the watchdog wins.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (!mem_we) rdata_d = mem_rdata;
          state_d = ST_DONE;
        end
`ifdef NES_CMD_TIMEOUT_EN
        else if (tmr_exp) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          rdata_d   = 8'hFF;
          state_d   = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        ack_d     = tgl_q;
        busy_d    = 1'b0;
        last_op_d = op_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      value_q   <= '0;
      tgl_q     <= 1'b0;
      op_q      <= '0;
      arg_q     <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      last_op_q <= '0;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      nes_reset <= 1'b0;
      nes_pause <= 1'b1;
    end else begin
      state_q   <= state_d;
      value_q   <= value;
      tgl_q     <= tgl_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      last_op_q <= last_op_d;
      rdata_q   <= rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      nes_reset <= nes_reset_d;
      nes_pause <= nes_pause_d;
    end
  end

  assign result = {ack_q, busy_q, err_q, last_op_q, 18'd0, rdata_q};

endmodule

// File: tb/tb_nes_cmd_ctrl.sv
// Bench for nes_cmd_ctrl: directed command table, randomized commands against a
// reference model, and async-reset / watchdog corner cases.
module tb_nes_cmd_ctrl;

  localparam int RMIN = 16;
  localparam int TMO  = 1024;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] value;
  logic [31:0] result;
  logic        mem_req, mem_we, mem_ack, nes_reset, nes_pause;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  logic       m_ack;
  logic       m_pause;
  logic [7:0] m_rdata;

  nes_cmd_ctrl #(.RESET_MIN(RMIN), .TIMEOUT_CYCLES(TMO)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (arst_n),
    .value         (value),
    .result        (result),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .nes_reset     (nes_reset),
    .nes_pause     (nes_pause)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    int          d;
    logic [7:0]  rd;
    bit          poke;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic bit timed_out(input logic [2:0] op, input int d);
    bit to = 1'b0;
`ifdef NES_CMD_TIMEOUT_EN
    to = (op == 3'd2 || op == 3'd3) && d >= TMO;
`endif
    return to;
  endfunction

  // Expected result word after a command, from the command's rules alone.
  function automatic logic [31:0] model_res(input logic [31:0] v, input int d, input logic [7:0] rd);
    logic [2:0] op = v[30:28];
    bit         to = timed_out(op, d);
    logic [7:0] r  = m_rdata;
    bit         e  = (op > 3'd4) || to;
    if (to) r = 8'hFF;
    else if (op == 3'd3) r = rd;
    return {v[31], 1'b0, e, op, 18'd0, r};
  endfunction

  // Issue one command, act as the NES bus (ack after d extra request cycles), then check.
  task automatic run_cmd(input logic [31:0] v, input int d, input logic [7:0] rd,
                         input bit poke, input logic [31:0] exp_res);
    logic [2:0]  op = v[30:28];
    logic [27:0] arg = v[27:0];
    logic [31:0] mr = model_res(v, d, rd);
    bit   is_mem = (op == 3'd2 || op == 3'd3);
    bit   to = timed_out(op, d);
    int   len, exp_lat, exp_req;
    int   done_k = -1, req_n = 0, req_rise = 0, req_first = -1, rst_c = 0, rst_first = -1;
    bit   unstable = 1'b0, prev_req;
    logic busy1 = 1'b0, p1 = 1'b0, p2 = 1'b0, exp_pause;
    logic we_c = 1'b0;
    logic [15:0] a_c = '0;
    logic [7:0]  w_c = '0;

    len = (int'(arg[15:0]) < RMIN) ? RMIN : int'(arg[15:0]);
    exp_pause = (op == 3'd4) ? arg[0] : m_pause;
    if (op == 3'd1)  exp_lat = 3 + len;
    else if (to)     exp_lat = 3 + TMO;
    else if (is_mem) exp_lat = 4 + d;
    else             exp_lat = 3;
    exp_req = !is_mem ? 0 : (to ? TMO : d + 1);

    @(negedge clk);
    value = v;
    prev_req = mem_req;
    for (int k = 0; k < 4000 && done_k < 0; k++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (k == 1) begin busy1 = result[30]; p1 = nes_pause; end
      if (k == 2) p2 = nes_pause;
      if (poke && k == 3) value = {v[31], 31'($urandom)};
      if (mem_req) begin
        req_n++;
        if (!prev_req) begin
          req_rise++;
          if (req_first < 0) begin
            req_first = k; we_c = mem_we; a_c = mem_addr; w_c = mem_wdata;
          end
        end else if ({mem_we, mem_addr, mem_wdata} != {we_c, a_c, w_c}) begin
          unstable = 1'b1;
        end
        if (req_n == d + 1) begin mem_ack = 1'b1; mem_rdata = rd; end
      end
      prev_req = mem_req;
      if (nes_reset) begin
        rst_c++;
        if (rst_first < 0) rst_first = k;
      end
      if (result[31] == v[31] && !result[30]) done_k = k;
    end
    mem_ack = 1'b0;

    chk("ack_latency", done_k, exp_lat);
    chk("result", result, exp_res);
    chk("busy_after_accept", {31'd0, busy1}, 32'd1);
    chk("pause_before", {31'd0, p1}, {31'd0, m_pause});
    chk("pause_update", {31'd0, p2}, {31'd0, exp_pause});
    chk("req_rises", req_rise, is_mem ? 1 : 0);
    chk("req_cycles", req_n, exp_req);
    chk("reset_cycles", rst_c, (op == 3'd1) ? len : 0);
    if (op == 3'd1) chk("reset_start", rst_first, 2);
    if (is_mem) begin
      chk("req_start", req_first, 2);
      chk("req_fields", {15'd0, we_c, a_c}, {15'd0, op == 3'd2, arg[23:8]});
      chk("req_wdata", {24'd0, w_c}, {24'd0, arg[7:0]});
      chk("req_stable", {31'd0, unstable}, 32'd0);
    end

    m_ack   = v[31];
    m_pause = exp_pause;
    m_rdata = mr[7:0];
  endtask

  vec_t tbl[12];

  initial begin
    logic [31:0] v;
    logic [2:0]  op;
    int          d;
    logic [7:0]  rd;
    int          n;
    bit          seen;

    tbl[0]  = '{32'h8000_0000, 0, 8'h00, 1'b0, 32'h8000_0000};
    tbl[1]  = '{32'h2012_345A, 5, 8'h77, 1'b0, 32'h0800_0000};
    tbl[2]  = '{32'hB012_3400, 3, 8'hC3, 1'b0, 32'h8C00_00C3};
    tbl[3]  = '{32'h1000_0004, 0, 8'h00, 1'b0, 32'h0400_00C3};
    tbl[4]  = '{32'hF000_0000, 0, 8'h00, 1'b0, 32'hBC00_00C3};
    tbl[5]  = '{32'h0000_0000, 0, 8'h00, 1'b0, 32'h0000_00C3};
    tbl[6]  = '{32'hC000_0000, 0, 8'h00, 1'b0, 32'h9000_00C3};
    tbl[7]  = '{32'h3000_AB00, 0, 8'h5A, 1'b1, 32'h0C00_005A};
    tbl[8]  = '{32'h9000_0020, 0, 8'h00, 1'b0, 32'h8400_005A};
    tbl[9]  = '{32'h4000_0001, 0, 8'h00, 1'b0, 32'h1000_005A};
    tbl[10] = '{32'hD000_0000, 0, 8'h00, 1'b0, 32'hB400_005A};
    tbl[11] = '{32'h2000_FF11, 1, 8'h99, 1'b1, 32'h0800_005A};

    arst_n = 1'b0; value = '0; mem_ack = 1'b0; mem_rdata = '0;
    m_ack = 1'b0; m_pause = 1'b1; m_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_pause", {31'd0, nes_pause}, 32'd1);
    chk("rst_bus", {14'd0, mem_req, mem_we, mem_addr}, 32'h0);
    chk("rst_misc", {23'd0, nes_reset, mem_wdata}, 32'h0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) run_cmd(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].poke, tbl[i].exp);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      v  = {~m_ack, op, 28'($urandom)};
      if (op == 3'd1) v[15:0] = 16'($urandom_range(0, 40));
      d  = $urandom_range(0, 8);
      rd = 8'($urandom);
      run_cmd(v, d, rd, 1'($urandom), model_res(v, d, rd));
    end

`ifdef NES_CMD_TIMEOUT_EN
    v = {~m_ack, 3'd3, 28'h0_4321_00};
    run_cmd(v, 2000, 8'h00, 1'b0, model_res(v, 2000, 8'h00));
`endif

    // Asynchronous reset while a read is outstanding and unacknowledged.
    @(negedge clk);
    value = {~m_ack, 3'd3, 28'h0_1234_00};
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      seen = mem_req;
      n++;
    end
    chk("req_before_arst", {31'd0, mem_req}, 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_result", result, 32'h0);
    chk("arst_pause", {31'd0, nes_pause}, 32'd1);
    @(negedge clk);
    value = '0;
    @(negedge clk);
    arst_n = 1'b1;
    m_ack = 1'b0; m_pause = 1'b1; m_rdata = '0;
    run_cmd(32'h8000_0000, 0, 8'h00, 1'b0, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
